// File: rtl/human_occupancy_tracker.sv
// Room occupancy tracker: debounced entry/exit channels drive a saturating BCD up/down
// counter with alarm hysteresis and 7-segment outputs. Optional build macro: LEADING_ZERO_BLANK_EN.
`timescale 1ns/1ps
module human_occupancy_tracker #(
    parameter int DIGITS          = 2,
    parameter int MAX_COUNT       = 99,
    parameter int ALARM_HI        = 80,
    parameter int ALARM_LO        = 75,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  entry_detected,
    input  logic                  exit_detected,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  alarm,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int BW = 4*DIGITS;
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int            x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_COUNT);
    localparam logic [BW-1:0] HI_BCD  = to_bcd(ALARM_HI);
    localparam logic [BW-1:0] LO_BCD  = to_bcd(ALARM_LO);

    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    logic [1:0] raw;
    logic [1:0] ev;
    assign raw = {exit_detected, entry_detected};

    // Per channel: 2-flop synchroniser, run-length debounce, then a registered rising-edge pulse
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic          s1_q, s2_q, f_q, fd_q, ev_q;
        logic [CW-1:0] dc_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
                f_q  <= 1'b0;
                fd_q <= 1'b0;
                ev_q <= 1'b0;
                dc_q <= '0;
            end else begin
                s1_q <= raw[ch];
                s2_q <= s1_q;
                if (s2_q != f_q) begin
                    if (dc_q == CW'(DEBOUNCE_CYCLES-1)) begin
                        f_q  <= s2_q;
                        dc_q <= '0;
                    end else begin
                        dc_q <= dc_q + 1'b1;
                    end
                end else begin
                    dc_q <= '0;
                end
                fd_q <= f_q;
                ev_q <= f_q & ~fd_q;
            end
        end

        assign ev[ch] = ev_q;
    end

    logic [BW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, alarm_q, alarm_d, full_q;

    // Count stage: clear wins, simultaneous entry/exit cancel
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            case (ev)
                2'b01: begin
                    if (count_q == MAX_BCD) ovf_d = 1'b1;
                    else                    count_d = bcd_inc(count_q);
                end
                2'b10: begin
                    if (count_q == '0) unf_d = 1'b1;
                    else               count_d = bcd_dec(count_q);
                end
                default: ;
            endcase
        end
        // Packed BCD of valid digits orders the same as the decimal value
        if (count_d > HI_BCD)       alarm_d = 1'b1;
        else if (count_d <= LO_BCD) alarm_d = 1'b0;
        else                        alarm_d = alarm_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            alarm_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            alarm_q <= alarm_d;
            full_q  <= (count_q == MAX_BCD);
        end
    end

    assign count_bcd = count_q;
    assign alarm     = alarm_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

`ifdef LEADING_ZERO_BLANK_EN
    logic nz;
    always_comb begin
        seg = '0;
        nz  = 1'b0;
        for (int i = DIGITS-1; i >= 0; i--) begin
            nz = nz | (count_q[4*i +: 4] != 4'd0);
            if (nz || i == 0) seg[7*i +: 7] = seg7(count_q[4*i +: 4]);
        end
    end
`else
    always_comb begin
        seg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = seg7(count_q[4*i +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_human_occupancy_tracker.sv
// Directed bench for human_occupancy_tracker at default parameters (2 digits, 99 max, 80/75 alarm, debounce 3).
`timescale 1ns/1ps
module tb_human_occupancy_tracker;

    logic        clk = 1'b0;
    logic        reset, entry_detected, exit_detected, clear;
    logic [7:0]  count_bcd;
    logic [13:0] seg;
    logic        alarm, full, overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;
    int occ      = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] DIG1_ZERO = 7'b0000000;
`else
    localparam logic [6:0] DIG1_ZERO = 7'b0111111;
`endif

    always #5 clk = ~clk;

    human_occupancy_tracker dut (
        .clk            (clk),
        .reset          (reset),
        .entry_detected (entry_detected),
        .exit_detected  (exit_detected),
        .clear          (clear),
        .count_bcd      (count_bcd),
        .seg            (seg),
        .alarm          (alarm),
        .full           (full),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    function automatic logic [7:0] bcd8(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic en, input logic ex, input int hi, input int lo);
        @(negedge clk);
        entry_detected = en;
        exit_detected  = ex;
        repeat (hi) @(negedge clk);
        entry_detected = 1'b0;
        exit_detected  = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; entry_detected = 1'b0; exit_detected = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_count", count_bcd, 8'h00);
        check_eq("rst_flags", {alarm, full, overflow, underflow}, 4'b0000);
        check_eq("rst_seg0", seg[6:0], 7'b0111111);
        check_eq("rst_seg1", seg[13:7], DIG1_ZERO);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Exact latency: raw high before edge k, count moves at edge k+6
        entry_detected = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("lat_before", count_bcd, 8'h00);
        @(negedge clk);
        check_eq("lat_at", count_bcd, 8'h01);
        entry_detected = 1'b0;
        repeat (10) @(negedge clk);
        occ = 1;

        // Up to 81, alarm rises on the 81st
        for (int i = 2; i <= 81; i++) begin
            pulse(1'b1, 1'b0, 8, 8);
            occ++;
            if (i == 80) begin
                check_eq("cnt80", count_bcd, bcd8(occ));
                check_eq("alarm80", alarm, 1'b0);
            end
        end
        check_eq("cnt81", count_bcd, 8'h81);
        check_eq("alarm81", alarm, 1'b1);
        check_eq("seg81_d1", seg[13:7], 7'b1111111);
        check_eq("seg81_d0", seg[6:0], 7'b0000110);

        // Hysteresis on the way down
        for (int i = 0; i < 6; i++) begin
            pulse(1'b0, 1'b1, 8, 8);
            occ--;
            check_eq("down_cnt", count_bcd, bcd8(occ));
            check_eq("down_alarm", alarm, (occ > 75) ? 1'b1 : 1'b0);
        end

        // Glitch rejection
        pulse(1'b1, 1'b0, 2, 12);
        check_eq("glitch2", count_bcd, 8'h75);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 2, 1);
        repeat (10) @(negedge clk);
        check_eq("train_entry", count_bcd, 8'h75);
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 2, 1);
        repeat (10) @(negedge clk);
        check_eq("train_exit", count_bcd, 8'h75);

        // Simultaneous events, then underflow
        for (int i = 0; i < 25; i++) pulse(1'b0, 1'b1, 8, 8);
        check_eq("cnt50", count_bcd, 8'h50);
        pulse(1'b1, 1'b1, 8, 8);
        check_eq("both_cnt", count_bcd, 8'h50);
        check_eq("both_flags", {overflow, underflow}, 2'b00);
        for (int i = 0; i < 49; i++) pulse(1'b0, 1'b1, 8, 8);
        check_eq("cnt01", count_bcd, 8'h01);
        pulse(1'b0, 1'b1, 8, 8);
        check_eq("cnt00", count_bcd, 8'h00);
        check_eq("unf_not_yet", underflow, 1'b0);
        pulse(1'b0, 1'b1, 8, 8);
        check_eq("cnt00_sat", count_bcd, 8'h00);
        check_eq("unf_set", underflow, 1'b1);

        // Saturation at 99, overflow, clear
        for (int i = 0; i < 98; i++) pulse(1'b1, 1'b0, 8, 8);
        check_eq("cnt98", count_bcd, 8'h98);
        check_eq("full98", full, 1'b0);
        pulse(1'b1, 1'b0, 8, 8);
        check_eq("cnt99", count_bcd, 8'h99);
        check_eq("full99", full, 1'b1);
        check_eq("ovf_not_yet", overflow, 1'b0);
        pulse(1'b1, 1'b0, 8, 8);
        check_eq("cnt99_sat", count_bcd, 8'h99);
        check_eq("ovf_set", overflow, 1'b1);
        check_eq("unf_sticky", underflow, 1'b1);
        check_eq("alarm99", alarm, 1'b1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_eq("clr_cnt", count_bcd, 8'h00);
        check_eq("clr_flags", {alarm, overflow, underflow}, 3'b000);
        check_eq("clr_full_lag", full, 1'b1);
        @(negedge clk);
        check_eq("clr_full", full, 1'b0);

        // Clear coinciding with an event discards the event
        entry_detected = 1'b1;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_eq("clr_prio", count_bcd, 8'h00);
        entry_detected = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("clr_prio_hold", count_bcd, 8'h00);

        // Asynchronous reset mid-count, input held across release
        for (int i = 0; i < 37; i++) pulse(1'b1, 1'b0, 8, 8);
        check_eq("cnt37", count_bcd, 8'h37);
        @(negedge clk);
        entry_detected = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_eq("async_cnt", count_bcd, 8'h00);
        check_eq("async_flags", {alarm, full, overflow, underflow}, 4'b0000);
        check_eq("async_seg1", seg[13:7], DIG1_ZERO);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("held_once", count_bcd, 8'h01);
        entry_detected = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, 8, 8);
        check_eq("cnt07", count_bcd, 8'h07);
        check_eq("seg07_d0", seg[6:0], 7'b0000111);
        check_eq("seg07_d1", seg[13:7], DIG1_ZERO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
